instr_queue: RTL and testbench
==============================

# instr_queue

Fetch-to-dispatch instruction queue. It buffers pre-decoded instruction packets (instr, PC, nPC) produced by the fetch unit and presents them in order to dispatch with a valid/ready handshake. It sits between `fetch_unit` and the dispatch stage. It supplies the `core_control_stall_fetch_unit` back-pressure term and is flushed on a ROB restart.

## Interface
Parameters:
- `IQ_DEPTH`, 4, number of entries; must be a power of two, at least 2.
- `LOG_IQ_DEPTH`, 2, equals log2(`IQ_DEPTH`).

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `from_fetch_ivalid`  in  1  enqueue request (fetch unit `to_pipeline_ivalid`).
- `from_fetch_instr`  in  32 (`word_t`)  instruction word.
- `from_fetch_PC`  in  14 (`pc_t`)  word-granular PC of the instruction.
- `from_fetch_nPC`  in  14 (`pc_t`)  predicted next PC.
- `from_pipeline_take_resolved`  in  1  restart/flush; same signal the fetch unit receives.
- `dispatch_ready`  in  1  dispatch accepts the head entry this cycle.
- `to_dispatch_valid`  out  1  head entry valid.
- `to_dispatch_instr`  out  32  head instruction.
- `to_dispatch_PC`  out  14  head PC.
- `to_dispatch_nPC`  out  14  head nPC.
- `stall_fetch_unit`  out  1  queue full; drives `core_control_stall_fetch_unit`.
- `iq_count`  out  `LOG_IQ_DEPTH`+1  current occupancy, 0..`IQ_DEPTH`.

## Operation
State and storage:
- Circular buffer of `IQ_DEPTH` entries, each {instr, PC, nPC}.
- `head` and `tail` pointers, each `LOG_IQ_DEPTH`+1 bits wide; the MSB is the wrap bit.
- Empty when `head == tail`.
- Full when the index bits are equal and the wrap bits differ.
- `iq_count` = `tail - head`, computed modulo 2^(`LOG_IQ_DEPTH`+1).

Enqueue (`enq`):
- `enq = from_fetch_ivalid & ~full & ~from_pipeline_take_resolved`.
- On `enq`, write the packet at `tail[LOG_IQ_DEPTH-1:0]` and increment `tail`.

Dequeue (`deq`):
- `deq = to_dispatch_valid & dispatch_ready`.
- On `deq`, increment `head`.

Outputs:
- `to_dispatch_valid = ~empty & ~from_pipeline_take_resolved`.
- Data outputs always show the entry at `head`. They are only meaningful while valid.
- `stall_fetch_unit = full`. It is a function of registered state only, so there is no combinational path from `from_fetch_ivalid` or `dispatch_ready`.

Simultaneous events:
- Enqueue and dequeue in the same cycle when not full: both pointers advance and the count is unchanged.
- When full, enqueue is blocked even if `dispatch_ready` is high. The freed slot is visible one cycle later.
- A flush has priority over everything else. On `from_pipeline_take_resolved`, next `head = tail = 0`, no enqueue, and no dequeue. Entry storage is not cleared.
- A `from_fetch_ivalid` that arrives while full is dropped, not an error. The fetch unit guarantees it will not assert, because it sees the stall.

No bypass: an entry enqueued into an empty queue is first visible to dispatch the following cycle.

## Timing
Reset values (asynchronous, `nRST` low):
- `head = tail = 0` and all entries zero.
- `to_dispatch_valid = 0`, `stall_fetch_unit = 0`, `iq_count = 0`.
- Data outputs are 0.

Latency and throughput:
- Enqueue-to-valid latency is 1 cycle.
- Sustained throughput is 1 enqueue and 1 dequeue per cycle.
- Back-to-back fill from empty: `stall_fetch_unit` rises the cycle after the `IQ_DEPTH`-th enqueue.
- `stall_fetch_unit` falls the cycle after the first dequeue while full.

Flush:
- In the flush cycle, `to_dispatch_valid` is 0.
- In the next cycle, the queue is empty and `stall_fetch_unit` is 0.
- The earliest post-flush enqueue is accepted in the cycle after the flush.

Other timing rules:
- Pointer wrap: after `IQ_DEPTH` enqueues the index wraps to 0 and the wrap bit toggles. Order is preserved across the wrap.
- Reset mid-operation: all state returns to reset values immediately. No packets survive.

## Test plan
- **Fill and stall.** Reset, then 4 enqueues with PC=0x10..0x13 and `dispatch_ready`=0.
  - `iq_count` reads 1,2,3,4.
  - `stall_fetch_unit` = 1 after the 4th enqueue.
  - A 5th `ivalid` with PC=0x14 is ignored; `iq_count` stays 4.
- **In-order drain.** From full, hold `dispatch_ready`=1.
  - `to_dispatch_PC` reads 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
  - `to_dispatch_valid` falls after the 4th dequeue.
  - `stall_fetch_unit` = 0 one cycle after the first dequeue.
- **Streaming with wrap.** `ivalid` and `dispatch_ready` both high for 10 cycles with PC=0x20..0x29.
  - Dispatch sees 0x20..0x28, each one cycle after its enqueue.
  - `iq_count` stays 1 from cycle 2 onward.
  - Pointers wrap twice with no loss or duplication.
- **Flush.** Hold 3 entries, then assert `take_resolved` together with `ivalid` (PC=0x30) and `dispatch_ready`=1.
  - `to_dispatch_valid` = 0 in the flush cycle and no dequeue occurs.
  - Next cycle `iq_count` = 0.
  - A following enqueue of PC=0x40 appears at the head one cycle later.
- **Full with simultaneous requests.** With the queue full, assert `ivalid` (PC=0x50) and `dispatch_ready`=1 together.
  - Only the dequeue occurs; `iq_count` = 3.
  - PC 0x50 is not stored.
- **Async reset mid-stream.** Drop `nRST` asynchronously with 2 entries held.
  - All outputs go to 0 immediately, before the next clock edge.
  - After release, the first enqueue of PC=0x60 is dispatched with `instr` and `nPC` intact.

Source files
------------

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-dispatch instruction queue
// Circular buffer of {instr, PC, nPC} packets with valid/ready dispatch and flush.
module instr_queue #(
   parameter int IQ_DEPTH     = 4,
   parameter int LOG_IQ_DEPTH = 2
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    from_fetch_ivalid,
   input  logic [31:0]             from_fetch_instr,
   input  logic [13:0]             from_fetch_PC,
   input  logic [13:0]             from_fetch_nPC,
   input  logic                    from_pipeline_take_resolved,
   input  logic                    dispatch_ready,
   output logic                    to_dispatch_valid,
   output logic [31:0]             to_dispatch_instr,
   output logic [13:0]             to_dispatch_PC,
   output logic [13:0]             to_dispatch_nPC,
   output logic                    stall_fetch_unit,
   output logic [LOG_IQ_DEPTH:0]   iq_count
);

   localparam logic [LOG_IQ_DEPTH:0] PTR_ONE = {{LOG_IQ_DEPTH{1'b0}}, 1'b1};

   logic [LOG_IQ_DEPTH:0]   head;
   logic [LOG_IQ_DEPTH:0]   tail;
   logic [LOG_IQ_DEPTH-1:0] head_idx;
   logic [LOG_IQ_DEPTH-1:0] tail_idx;
   logic [31:0]             instr_mem [IQ_DEPTH];
   logic [13:0]             pc_mem    [IQ_DEPTH];
   logic [13:0]             npc_mem   [IQ_DEPTH];
   logic                    empty;
   logic                    full;
   logic                    enq;
   logic                    deq;

   assign head_idx = head[LOG_IQ_DEPTH-1:0];
   assign tail_idx = tail[LOG_IQ_DEPTH-1:0];

   // Wrap bit distinguishes full from empty when the index bits match.
   assign empty = (head == tail);
   assign full  = (head_idx == tail_idx) && (head[LOG_IQ_DEPTH] != tail[LOG_IQ_DEPTH]);

   assign enq = from_fetch_ivalid & ~full & ~from_pipeline_take_resolved;
   assign deq = to_dispatch_valid & dispatch_ready;

   assign to_dispatch_valid = ~empty & ~from_pipeline_take_resolved;
   assign to_dispatch_instr = instr_mem[head_idx];
   assign to_dispatch_PC    = pc_mem[head_idx];
   assign to_dispatch_nPC   = npc_mem[head_idx];
   assign stall_fetch_unit  = full;
   assign iq_count          = tail - head;

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         head <= '0;
         tail <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
            npc_mem[i]   <= '0;
         end
      end else if (from_pipeline_take_resolved) begin
         // Flush resets pointers only; stale entries are unreachable once empty.
         head <= '0;
         tail <= '0;
      end else begin
         if (enq) begin
            instr_mem[tail_idx] <= from_fetch_instr;
            pc_mem[tail_idx]    <= from_fetch_PC;
            npc_mem[tail_idx]   <= from_fetch_nPC;
            tail                <= tail + PTR_ONE;
         end
         if (deq) begin
            head <= head + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - self-checking bench for instr_queue
// Directed test-plan steps then random traffic, checked against a queue model.
module tb_instr_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] instr;
      logic [13:0] pc;
      logic [13:0] npc;
   } pkt_t;

   logic        CLK;
   logic        nRST;
   logic        from_fetch_ivalid;
   logic [31:0] from_fetch_instr;
   logic [13:0] from_fetch_PC;
   logic [13:0] from_fetch_nPC;
   logic        from_pipeline_take_resolved;
   logic        dispatch_ready;
   logic        to_dispatch_valid;
   logic [31:0] to_dispatch_instr;
   logic [13:0] to_dispatch_PC;
   logic [13:0] to_dispatch_nPC;
   logic        stall_fetch_unit;
   logic [2:0]  iq_count;

   pkt_t model[$];
   int   n_cmp = 0;
   int   n_err = 0;

   instr_queue #(.IQ_DEPTH(DEPTH), .LOG_IQ_DEPTH(2)) dut (
      .CLK                         (CLK),
      .nRST                        (nRST),
      .from_fetch_ivalid           (from_fetch_ivalid),
      .from_fetch_instr            (from_fetch_instr),
      .from_fetch_PC               (from_fetch_PC),
      .from_fetch_nPC              (from_fetch_nPC),
      .from_pipeline_take_resolved (from_pipeline_take_resolved),
      .dispatch_ready              (dispatch_ready),
      .to_dispatch_valid           (to_dispatch_valid),
      .to_dispatch_instr           (to_dispatch_instr),
      .to_dispatch_PC              (to_dispatch_PC),
      .to_dispatch_nPC             (to_dispatch_nPC),
      .stall_fetch_unit            (stall_fetch_unit),
      .iq_count                    (iq_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(to_dispatch_valid), 32'd0);
      check({tag, "_stall"}, 32'(stall_fetch_unit), 32'd0);
      check({tag, "_count"}, 32'(iq_count), 32'd0);
      check({tag, "_instr"}, to_dispatch_instr, 32'd0);
      check({tag, "_pc"}, 32'(to_dispatch_PC), 32'd0);
      check({tag, "_npc"}, 32'(to_dispatch_nPC), 32'd0);
   endtask

   // One cycle: drive at posedge+1, check at negedge, advance the model at posedge.
   task automatic step(input logic iv, input logic [13:0] pc, input logic tk, input logic rdy);
      logic exp_valid;
      logic was_full;
      pkt_t p;
      from_fetch_ivalid           = iv;
      from_fetch_instr            = $urandom;
      from_fetch_PC               = pc;
      from_fetch_nPC              = pc + 14'd1;
      from_pipeline_take_resolved = tk;
      dispatch_ready              = rdy;
      @(negedge CLK);
      exp_valid = (model.size() != 0) && !tk;
      was_full  = (model.size() == DEPTH);
      check("valid", 32'(to_dispatch_valid), 32'(exp_valid));
      check("stall", 32'(stall_fetch_unit), 32'(was_full));
      check("count", 32'(iq_count), 32'(model.size()));
      if (exp_valid) begin
         check("instr", to_dispatch_instr, model[0].instr);
         check("pc", 32'(to_dispatch_PC), 32'(model[0].pc));
         check("npc", 32'(to_dispatch_nPC), 32'(model[0].npc));
      end
      @(posedge CLK);
      if (tk) begin
         model.delete();
      end else begin
         if (exp_valid && rdy) void'(model.pop_front());
         if (iv && !was_full) begin
            p.instr = from_fetch_instr;
            p.pc    = from_fetch_PC;
            p.npc   = from_fetch_nPC;
            model.push_back(p);
         end
      end
      #1;
   endtask

   initial begin
      nRST                        = 1'b0;
      from_fetch_ivalid           = 1'b0;
      from_fetch_instr            = '0;
      from_fetch_PC               = '0;
      from_fetch_nPC              = '0;
      from_pipeline_take_resolved = 1'b0;
      dispatch_ready              = 1'b0;
      #2;
      check_all_zero("reset");
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Fill and stall, including a dropped 5th request
      for (int i = 0; i < 5; i++) step(1'b1, 14'h10 + 14'(i), 1'b0, 1'b0);
      check("full_count", 32'(iq_count), 32'd4);
      check("full_stall", 32'(stall_fetch_unit), 32'd1);

      // In-order drain
      for (int i = 0; i < 5; i++) step(1'b0, 14'h0, 1'b0, 1'b1);

      // Streaming with pointer wrap
      for (int i = 0; i < 10; i++) step(1'b1, 14'h20 + 14'(i), 1'b0, 1'b1);
      step(1'b0, 14'h0, 1'b0, 1'b1);

      // Flush with simultaneous enqueue and dispatch_ready
      for (int i = 0; i < 3; i++) step(1'b1, 14'h30 + 14'(i), 1'b0, 1'b0);
      step(1'b1, 14'h30, 1'b1, 1'b1);
      check("post_flush_count", 32'(iq_count), 32'd0);
      step(1'b1, 14'h40, 1'b0, 1'b0);
      step(1'b0, 14'h0, 1'b0, 1'b1);

      // Full with simultaneous enqueue and dequeue
      for (int i = 0; i < 4; i++) step(1'b1, 14'h50 + 14'(i), 1'b0, 1'b0);
      step(1'b1, 14'h50, 1'b0, 1'b1);
      check("full_simul_count", 32'(iq_count), 32'd3);
      for (int i = 0; i < 4; i++) step(1'b0, 14'h0, 1'b0, 1'b1);

      // Async reset mid-stream with two entries held
      for (int i = 0; i < 2; i++) step(1'b1, 14'h58 + 14'(i), 1'b0, 1'b0);
      from_fetch_ivalid = 1'b0;
      dispatch_ready    = 1'b0;
      #2;
      nRST = 1'b0;
      #1;
      check_all_zero("async_reset");
      model.delete();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      step(1'b1, 14'h60, 1'b0, 1'b0);
      step(1'b0, 14'h0, 1'b0, 1'b1);

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, 14'($urandom), ($urandom % 20) == 0, ($urandom % 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
